retire_checker: RTL and testbench
=================================

Name: retire_checker

Overview:
- Synthesizable, self-checking retirement monitor for the single-cycle RISC-V datapath.
- Takes the role of the hand-timed phase bench: expected (PC, result) pairs are preloaded into an internal buffer, then every retired instruction is compared in order.
- Reports pass/fail, counts, first-failure details and a watchdog timeout.
- Parametrised in data width, buffer depth and stop-on-fail mode, so the same block serves the current 64-bit datapath and future variants.

Parameters:
- XLEN, 64, width of PC and result values.
- DEPTH, 16, number of expected entries; power of two, at least 2.
- TIMEOUT, 64, maximum consecutive RUN cycles without a retire before failing; at least 1.
- STOP_ON_FAIL, 1, 1 = enter DONE on first mismatch; 0 = keep checking until all entries are consumed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- exp_wr  in  1  write one expected entry (accepted in IDLE only).
- exp_pc  in  XLEN  expected PC for the entry.
- exp_val  in  XLEN  expected result value for the entry.
- start  in  1  begin checking (accepted in IDLE only).
- retire_valid  in  1  datapath retired an instruction this cycle.
- retire_pc  in  XLEN  PC of the retired instruction.
- retire_val  in  XLEN  result of the retired instruction (output_reg).
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done: no mismatch and no timeout.
- timed_out  out  1  watchdog expired.
- exp_full  out  1  buffer holds DEPTH entries.
- retired_count  out  $clog2(DEPTH)+1  entries checked so far.
- mismatch_count  out  $clog2(DEPTH)+1  mismatches seen.
- first_fail_idx  out  $clog2(DEPTH)  index of the first mismatch.
- first_fail_pc  out  XLEN  retire_pc at the first mismatch.

Behaviour:
- Clocking and reset: one clock `clk`; reset is synchronous and active-high on port `reset`.
- Reset values:
  - State IDLE.
  - All counters and pointers 0.
  - busy, done, pass, timed_out, exp_full all 0.
  - first_fail_idx 0, first_fail_pc 0.
  - Buffer contents are don't-care; loaded count is cleared.
- Reset mid-RUN aborts the check with no residual state.
- IDLE:
  - exp_wr with exp_full=0 writes the buffer at wr_ptr and increments the loaded count.
  - exp_wr with exp_full=1 is ignored; the count does not wrap.
  - start with loaded count > 0 enters RUN the next cycle, with rd_ptr=0 and the watchdog cleared.
  - start with loaded count 0 enters DONE with pass=1.
  - start and exp_wr in the same cycle: the write is taken first, and that entry is included in the run.
  - retire_valid is ignored.
- RUN:
  - Each retire_valid cycle compares retire_pc and retire_val against entry[rd_ptr], then increments rd_ptr and retired_count.
  - A mismatch in either field increments mismatch_count.
  - On the first mismatch only, first_fail_idx and first_fail_pc are latched.
  - The watchdog increments on every cycle without retire_valid and clears on retire.
  - Watchdog reaching TIMEOUT sets timed_out=1 and enters DONE.
  - Retiring the last loaded entry enters DONE on the next cycle.
  - With STOP_ON_FAIL=1, a mismatch enters DONE on the next cycle; the failing retire is still counted.
  - exp_wr and start are ignored.
  - Latency: compare results appear in the counters one cycle after the retire edge.
- DONE:
  - done=1; pass = (mismatch_count==0) & ~timed_out.
  - Outputs hold until reset or start.
  - start returns to IDLE with the buffer preserved (wr_ptr and loaded count kept), so the same program can be re-run.
  - Counters, timed_out and first_fail fields clear on that transition.
- Arithmetic:
  - Counters are unsigned and saturate at DEPTH.
  - Pointers are $clog2(DEPTH) bits and wrap naturally; they cannot overrun because the loaded count is at most DEPTH.
  - Comparisons are full XLEN-bit equality; no sign handling.

Test Plan:
- 5-pass run: load 5 entries (pc 0,4,8,12,16; val 0x1..0x5), start, retire all five matching one per cycle -> done=1, pass=1, retired_count=5, mismatch_count=0, DONE reached 1 cycle after the 5th retire.
- Mismatch with STOP_ON_FAIL=1: same load, 3rd retire has val 0x9 -> done after the 3rd retire, pass=0, mismatch_count=1, first_fail_idx=2, first_fail_pc=8, retired_count=3.
- Mismatch with STOP_ON_FAIL=0: mismatches at entries 1 and 3 -> all 5 retired, mismatch_count=2, first_fail_idx=1, first_fail_pc=4.
- Watchdog with TIMEOUT=8: load 2 entries, start, retire one, then idle 8 cycles -> timed_out=1, done=1, pass=0, retired_count=1.
- Full buffer and edge start: with DEPTH=4, write 6 entries -> exp_full=1 and only 4 stored. Start with 0 entries loaded (after reset) -> done with pass=1. Start asserted together with the last exp_wr -> that entry is included.
- Reset and re-run: reset asserted mid-RUN -> all outputs 0 and state IDLE next cycle. Separately, start from DONE, then start again -> the identical check repeats with counters starting from 0.

Source files
------------

// File: rtl/retire_checker_if.sv
// retire_checker_if: groups the preload, start, retire and status signals of
// retire_checker.
//   master : drives exp_wr/exp_pc/exp_val, start, retire_valid/retire_pc/
//            retire_val and observes the status outputs.
//   slave  : the checker itself.
interface retire_checker_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic            exp_wr;
  logic [XLEN-1:0] exp_pc;
  logic [XLEN-1:0] exp_val;
  logic            start;
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc;
  logic [XLEN-1:0] retire_val;
  logic            busy;
  logic            done;
  logic            pass;
  logic            timed_out;
  logic            exp_full;
  logic [CW-1:0]   retired_count;
  logic [CW-1:0]   mismatch_count;
  logic [AW-1:0]   first_fail_idx;
  logic [XLEN-1:0] first_fail_pc;

  modport master (
    output exp_wr, exp_pc, exp_val, start, retire_valid, retire_pc, retire_val,
    input  busy, done, pass, timed_out, exp_full, retired_count,
           mismatch_count, first_fail_idx, first_fail_pc
  );

  modport slave (
    input  exp_wr, exp_pc, exp_val, start, retire_valid, retire_pc, retire_val,
    output busy, done, pass, timed_out, exp_full, retired_count,
           mismatch_count, first_fail_idx, first_fail_pc
  );
endinterface

// File: rtl/retire_checker.sv
// retire_checker: in-order retirement monitor. Expected (pc, val) pairs are
// preloaded in IDLE; after start each retired instruction is compared against
// the next entry. Reports pass/fail, counts, first failure and a watchdog.
//   clk, reset : clock, synchronous active-high reset
//   bus        : retire_checker_if.slave (preload, start, retire, status)
module retire_checker #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 64,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input logic             clk,
  input logic             reset,
  retire_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nx;

  logic [XLEN-1:0] mem_pc  [DEPTH];
  logic [XLEN-1:0] mem_val [DEPTH];

  logic [AW-1:0]   wr_ptr, rd_ptr, ff_idx;
  logic [CW-1:0]   loaded, retired_cnt, mis_cnt;
  logic [WW-1:0]   wdog;
  logic            timed_out_q;
  logic [XLEN-1:0] ff_pc;

  logic            full, wr_take, retire, mism, last, wd_exp;
  logic [CW-1:0]   loaded_nx, ret_inc;
  logic [WW-1:0]   wd_inc;

  assign full      = (loaded == CW'(DEPTH));
  assign wr_take   = (state == S_IDLE) & bus.exp_wr & ~full;
  // A write in the same cycle as start counts toward the run.
  assign loaded_nx = wr_take ? loaded + CW'(1) : loaded;
  assign retire    = (state == S_RUN) & bus.retire_valid;
  assign mism      = retire & ((bus.retire_pc  != mem_pc[rd_ptr]) |
                               (bus.retire_val != mem_val[rd_ptr]));
  assign ret_inc   = retired_cnt + CW'(1);
  assign last      = (ret_inc == loaded);
  assign wd_inc    = wdog + WW'(1);
  assign wd_exp    = (state == S_RUN) & ~bus.retire_valid & (wd_inc == WW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) state_nx = (loaded_nx != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        if (retire) begin
          if (last || (mism && STOP_ON_FAIL)) state_nx = S_DONE;
        end else if (wd_exp) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: if (bus.start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Buffer contents need no reset; only the loaded count qualifies them.
  always_ff @(posedge clk) begin
    if (wr_take) begin
      mem_pc[wr_ptr]  <= bus.exp_pc;
      mem_val[wr_ptr] <= bus.exp_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      loaded      <= '0;
      retired_cnt <= '0;
      mis_cnt     <= '0;
      wdog        <= '0;
      timed_out_q <= 1'b0;
      ff_idx      <= '0;
      ff_pc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_take) begin
            wr_ptr <= wr_ptr + AW'(1);
            loaded <= loaded_nx;
          end
          if (bus.start) begin
            rd_ptr <= '0;
            wdog   <= '0;
          end
        end
        S_RUN: begin
          if (retire) begin
            rd_ptr      <= rd_ptr + AW'(1);
            retired_cnt <= (retired_cnt == CW'(DEPTH)) ? retired_cnt : ret_inc;
            wdog        <= '0;
            if (mism) begin
              mis_cnt <= (mis_cnt == CW'(DEPTH)) ? mis_cnt : mis_cnt + CW'(1);
              if (mis_cnt == '0) begin
                ff_idx <= rd_ptr;
                ff_pc  <= bus.retire_pc;
              end
            end
          end else begin
            wdog <= wd_inc;
            if (wd_exp) timed_out_q <= 1'b1;
          end
        end
        S_DONE: begin
          // Re-arm: results clear, the loaded program is kept for a re-run.
          if (bus.start) begin
            rd_ptr      <= '0;
            retired_cnt <= '0;
            mis_cnt     <= '0;
            wdog        <= '0;
            timed_out_q <= 1'b0;
            ff_idx      <= '0;
            ff_pc       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = (state == S_RUN);
  assign bus.done           = (state == S_DONE);
  assign bus.pass           = (state == S_DONE) & (mis_cnt == '0) & ~timed_out_q;
  assign bus.timed_out      = timed_out_q;
  assign bus.exp_full       = full;
  assign bus.retired_count  = retired_cnt;
  assign bus.mismatch_count = mis_cnt;
  assign bus.first_fail_idx = ff_idx;
  assign bus.first_fail_pc  = ff_pc;
endmodule

// File: tb/tb_retire_checker.sv
// Scoreboard bench for retire_checker. Three instances cover the
// parameter variants: A (DEPTH 8, TIMEOUT 8, stop on fail), B (DEPTH 8,
// keep checking), C (DEPTH 4, stop on fail). Stimulus pushes the expected
// final result of each run; per-instance monitors pop and compare whenever
// done rises, including the cycle at which it rises.
module tb_retire_checker;
  typedef struct {
    string       tag;
    logic        pass, to;
    logic [63:0] ret, mis, idx, pc;
    int          rise;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pcyc = 0;
  int   n_chk = 0, n_err = 0;
  rec_t qa[$], qb[$], qc[$];
  logic da_q = 1'b0, db_q = 1'b0, dc_q = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  retire_checker_if #(.XLEN(64), .DEPTH(8)) ifa ();
  retire_checker_if #(.XLEN(64), .DEPTH(8)) ifb ();
  retire_checker_if #(.XLEN(64), .DEPTH(4)) ifc ();

  retire_checker #(.XLEN(64), .DEPTH(8), .TIMEOUT(8), .STOP_ON_FAIL(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  retire_checker #(.XLEN(64), .DEPTH(8), .TIMEOUT(8), .STOP_ON_FAIL(1'b0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  retire_checker #(.XLEN(64), .DEPTH(4), .TIMEOUT(8), .STOP_ON_FAIL(1'b1))
    dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(string tag, logic pass, logic to, int ret, int mis,
                              int idx, logic [63:0] pc);
    rec_t r;
    r.tag = tag; r.pass = pass; r.to = to;
    r.ret = 64'(ret); r.mis = 64'(mis); r.idx = 64'(idx); r.pc = pc; r.rise = 0;
    return r;
  endfunction

  task automatic drv(int d, logic wr, logic [63:0] epc, logic [63:0] evl, logic st,
                     logic rv, logic [63:0] rpc, logic [63:0] rvl);
    case (d)
      0: begin ifa.exp_wr = wr; ifa.exp_pc = epc; ifa.exp_val = evl; ifa.start = st;
               ifa.retire_valid = rv; ifa.retire_pc = rpc; ifa.retire_val = rvl; end
      1: begin ifb.exp_wr = wr; ifb.exp_pc = epc; ifb.exp_val = evl; ifb.start = st;
               ifb.retire_valid = rv; ifb.retire_pc = rpc; ifb.retire_val = rvl; end
      default: begin ifc.exp_wr = wr; ifc.exp_pc = epc; ifc.exp_val = evl; ifc.start = st;
               ifc.retire_valid = rv; ifc.retire_pc = rpc; ifc.retire_val = rvl; end
    endcase
  endtask

  task automatic step(int d, logic wr, logic [63:0] epc, logic [63:0] evl, logic st,
                      logic rv, logic [63:0] rpc, logic [63:0] rvl);
    drv(d, wr, epc, evl, st, rv, rpc, rvl);
    @(negedge clk);
    drv(d, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic snap(int d, output rec_t r, output logic busy, output logic done,
                      output logic full);
    r.tag = "";
    r.rise = pcyc;
    case (d)
      0: begin r.pass = ifa.pass; r.to = ifa.timed_out; r.ret = 64'(ifa.retired_count);
               r.mis = 64'(ifa.mismatch_count); r.idx = 64'(ifa.first_fail_idx);
               r.pc = ifa.first_fail_pc; busy = ifa.busy; done = ifa.done; full = ifa.exp_full; end
      1: begin r.pass = ifb.pass; r.to = ifb.timed_out; r.ret = 64'(ifb.retired_count);
               r.mis = 64'(ifb.mismatch_count); r.idx = 64'(ifb.first_fail_idx);
               r.pc = ifb.first_fail_pc; busy = ifb.busy; done = ifb.done; full = ifb.exp_full; end
      default: begin r.pass = ifc.pass; r.to = ifc.timed_out; r.ret = 64'(ifc.retired_count);
               r.mis = 64'(ifc.mismatch_count); r.idx = 64'(ifc.first_fail_idx);
               r.pc = ifc.first_fail_pc; busy = ifc.busy; done = ifc.done; full = ifc.exp_full; end
    endcase
  endtask

  function automatic int qsize(int d);
    case (d)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic push(int d, rec_t e);
    case (d)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Monitor side: compare the DUT's final status against the oldest expectation.
  task automatic mon(int d);
    rec_t a, e;
    logic b, dn, f;
    snap(d, a, b, dn, f);
    if (qsize(d) == 0) begin
      n_chk++; n_err++;
      $display("FAIL unexpected_done dut%0d at cycle %0d", d, pcyc);
      return;
    end
    case (d)
      0: e = qa.pop_front();
      1: e = qb.pop_front();
      default: e = qc.pop_front();
    endcase
    chk({e.tag, ".pass"},      64'(a.pass), 64'(e.pass));
    chk({e.tag, ".timed_out"}, 64'(a.to),   64'(e.to));
    chk({e.tag, ".retired"},   a.ret,       e.ret);
    chk({e.tag, ".mismatch"},  a.mis,       e.mis);
    chk({e.tag, ".ff_idx"},    a.idx,       e.idx);
    chk({e.tag, ".ff_pc"},     a.pc,        e.pc);
    chk({e.tag, ".done_cycle"}, 64'(a.rise), 64'(e.rise));
  endtask

  always @(negedge clk) begin
    if (ifa.done === 1'b1 && !da_q) mon(0);
    if (ifb.done === 1'b1 && !db_q) mon(1);
    if (ifc.done === 1'b1 && !dc_q) mon(2);
    da_q = (ifa.done === 1'b1);
    db_q = (ifb.done === 1'b1);
    dc_q = (ifc.done === 1'b1);
  end

  task automatic wait_drain(int d, string tag);
    for (int i = 0; i < 40; i++) begin
      if (qsize(d) == 0) break;
      @(negedge clk);
    end
    if (qsize(d) != 0) begin
      n_chk++; n_err++;
      $display("FAIL %s.timeout: done never rose within 40 cycles", tag);
      case (d)
        0: qa.delete();
        1: qb.delete();
        default: qc.delete();
      endcase
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_zero(int d, string tag);
    rec_t a;
    logic b, dn, f;
    snap(d, a, b, dn, f);
    chk({tag, ".busy"}, 64'(b), 64'd0);
    chk({tag, ".done"}, 64'(dn), 64'd0);
    chk({tag, ".pass"}, 64'(a.pass), 64'd0);
    chk({tag, ".timed_out"}, 64'(a.to), 64'd0);
    chk({tag, ".exp_full"}, 64'(f), 64'd0);
    chk({tag, ".retired"}, a.ret, 64'd0);
    chk({tag, ".mismatch"}, a.mis, 64'd0);
    chk({tag, ".ff_idx"}, a.idx, 64'd0);
    chk({tag, ".ff_pc"}, a.pc, 64'd0);
  endtask

  task automatic load(int d, int n);
    for (int i = 0; i < n; i++) step(d, 1'b1, 64'(4 * i), 64'(i + 1), 1'b0, 1'b0, '0, '0);
  endtask

  // Retire entries 0..n-1 in order; entries bad_a/bad_b get value 0x9.
  // The expectation is pushed just before the last retire, with done due
  // on the first cycle after that retire edge.
  task automatic run(int d, int n, int bad_a, int bad_b, rec_t e);
    logic [63:0] v;
    for (int i = 0; i < n; i++) begin
      v = (i == bad_a || i == bad_b) ? 64'h9 : 64'(i + 1);
      if (i == n - 1) begin
        e.rise = pcyc + 1;
        push(d, e);
      end
      step(d, 1'b0, '0, '0, 1'b0, 1'b1, 64'(4 * i), v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rec_t e, a;
    logic b, dn, f;
    for (int d = 0; d < 3; d++) drv(d, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    do_reset();
    chk_zero(0, "reset_a");
    chk_zero(2, "reset_c");

    // Five matching retires, then re-run the same program from DONE.
    load(0, 5);
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    snap(0, a, b, dn, f);
    chk("run5.busy", 64'(b), 64'd1);
    run(0, 5, -1, -1, mk("run5", 1, 0, 5, 0, 0, 0));
    wait_drain(0, "run5");
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    chk_zero(0, "rearm");
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    run(0, 5, -1, -1, mk("rerun5", 1, 0, 5, 0, 0, 0));
    wait_drain(0, "rerun5");

    // Stop on the first mismatch (entry 2).
    do_reset();
    load(0, 5);
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    run(0, 3, 2, -1, mk("stop", 0, 0, 3, 1, 2, 64'h8));
    wait_drain(0, "stop");

    // Watchdog: one retire, then 8 idle cycles.
    do_reset();
    load(0, 2);
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    e = mk("wdog", 0, 1, 1, 0, 0, 0);
    e.rise = pcyc + 9;
    push(0, e);
    step(0, 1'b0, '0, '0, 1'b0, 1'b1, 64'h0, 64'h1);
    wait_drain(0, "wdog");

    // Reset in the middle of a run, then start with nothing loaded.
    do_reset();
    load(0, 3);
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    step(0, 1'b0, '0, '0, 1'b0, 1'b1, 64'h0, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero(0, "midrst");
    e = mk("empty", 1, 0, 0, 0, 0, 0);
    e.rise = pcyc + 1;
    push(0, e);
    step(0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    wait_drain(0, "empty");

    // Keep checking past mismatches at entries 1 and 3.
    do_reset();
    load(1, 5);
    step(1, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    run(1, 5, 1, 3, mk("nostop", 0, 0, 5, 2, 1, 64'h4));
    wait_drain(1, "nostop");

    // DEPTH 4: six writes keep only the first four.
    do_reset();
    load(2, 6);
    snap(2, a, b, dn, f);
    chk("full.exp_full", 64'(f), 64'd1);
    step(2, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    run(2, 4, -1, -1, mk("full", 1, 0, 4, 0, 0, 0));
    wait_drain(2, "full");

    // Start together with the last write: that entry is part of the run.
    do_reset();
    load(2, 2);
    step(2, 1'b1, 64'h8, 64'h3, 1'b1, 1'b0, '0, '0);
    run(2, 3, -1, -1, mk("wrstart", 1, 0, 3, 0, 0, 0));
    wait_drain(2, "wrstart");

    // PC-only mismatch on the first retire.
    do_reset();
    load(2, 2);
    step(2, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    e = mk("pcmis", 0, 0, 1, 1, 0, 64'h100);
    e.rise = pcyc + 1;
    push(2, e);
    step(2, 1'b0, '0, '0, 1'b0, 1'b1, 64'h100, 64'h1);
    wait_drain(2, "pcmis");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
